cpu_control_fsm: RTL and testbench
==================================

# cpu_control_fsm

Multi-cycle control state machine for the 8-bit simplified CPU. It fetches instructions from synchronous program memory and decodes them. It sequences each instruction through execute and writeback, driving the 3-bit select of the 6-input ALU result multiplexer and the register-file read/write controls. It sits between program memory, the register file and the ALU/result-mux datapath.

## Interface
- `PC_W`, default 8: program counter / memory address width.
- `RESET_PC`, default 0: PC value loaded by reset.
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `run`, input, 1: start / continue execution; level-sensitive.
- `mem_addr`, output, PC_W: program memory address.
- `mem_rd`, output, 1: memory read strobe. Data is valid on `mem_rdata` exactly one cycle later.
- `mem_rdata`, input, 8: program memory read data.
- `alu_sel`, output, 3: result-mux select; 0–5 are valid ALU operations.
- `rf_raddr_a`, output, 2: register-file read address, operand A (= rd).
- `rf_raddr_b`, output, 2: register-file read address, operand B (= rs).
- `rf_waddr`, output, 2: register-file write address.
- `rf_we`, output, 1: register-file write enable, single-cycle pulse.
- `rf_wsrc`, output, 1: write source; 0 = ALU result, 1 = `imm`.
- `imm`, output, 8: immediate byte latched for LDI.
- `busy`, output, 1: high in every state except IDLE and HALT.
- `halted`, output, 1: high in HALT.

## Operation
- Instruction byte fields:
  - [7:5] opcode.
  - [4:3] rd.
  - [2:1] rs.
  - [0] ignored.
- Opcodes 0–5: ALU op. `alu_sel`=opcode, rd ← rd op rs.
- Opcode 6: LDI. The next byte is the immediate, and rd ← imm.
- Opcode 7: HLT.
- States: IDLE, FETCH, DECODE, EXEC, WB, IMM_FETCH, IMM_LATCH, HALT.
- Transitions:
  - IDLE→FETCH when `run`=1.
  - FETCH→DECODE. `mem_rd`=1, `mem_addr`=PC.
  - DECODE: latch `mem_rdata` into IR. Then:
    - opcode 0–5 → EXEC.
    - opcode 6 → IMM_FETCH.
    - opcode 7 → HALT.
  - EXEC→WB. `alu_sel`, `rf_raddr_a`, `rf_raddr_b` are driven from IR.
  - IMM_FETCH→IMM_LATCH. PC←PC+1; `mem_rd`=1, `mem_addr`=PC+1.
  - IMM_LATCH→WB. `imm` ← `mem_rdata`.
  - WB: `rf_we`=1, `rf_waddr`=rd, PC←PC+1. `alu_sel` and the read addresses are held from EXEC. Next state is FETCH if `run`=1, otherwise IDLE.
  - HALT: sticky. It is left only by `rst`.
- Outputs are Moore-decoded from state + IR. Outside their active states:
  - `mem_rd`, `rf_we`, `rf_wsrc` are 0.
  - `alu_sel` is 0.
  - `mem_addr` = PC.
- PC arithmetic is modulo 2^PC_W: PC=0xFF+1 → 0x00. An LDI whose opcode is at 0xFF reads its immediate from 0x00.
- `run` is sampled only in IDLE and WB. Deasserting it mid-instruction completes that instruction and then parks in IDLE with PC pointing at the next instruction.

## Timing
- Reset (asynchronous, any state):
  - State=IDLE, PC=RESET_PC, IR=0, `imm`=0.
  - All outputs 0, except `mem_addr`=RESET_PC.
- Latency from entering FETCH:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDI: 5 cycles.
  - HLT: HALT reached on the 3rd edge.
- The `rf_we` pulse lasts exactly 1 cycle per ALU/LDI instruction. It never occurs for HLT.
- Back-to-back instructions with `run`=1 produce no idle cycle: WB is followed directly by FETCH.
- Reset asserted during WB: the register write in that cycle is suppressed, because `rf_we` drops asynchronously.

## Structure
- `cpu_pkg` holds:
  - opcode constants: OP_LDI=6, OP_HLT=7, ALU op codes 0–5 matching the result-mux select encoding.
  - the state enum.
  - instruction field position constants.
- Sub-module `cpu_ctrl_decode` (combinational): IR → opcode class (alu/ldi/hlt), `alu_sel`, rd, rs.
- Top level: state register, PC, IR, `imm` registers, output decode.

## Test plan
- Reset: assert `rst` with `run`=1. Required while `rst` is high: all outputs 0, `mem_addr`=0x00, `busy`=0. After release: FETCH begins on the first edge.
- ALU op: memory[0]=0x2A (opcode 1, rd=1, rs=1). Required:
  - `mem_rd` in cycle 1.
  - `alu_sel`=1 in EXEC and WB.
  - `rf_we`=1, `rf_waddr`=1, `rf_wsrc`=0 in cycle 4.
  - PC=0x01 afterwards.
- LDI: memory[0]=0xD0 (LDI r2), memory[1]=0x5A. Required in cycle 5: `rf_we`=1, `rf_waddr`=2, `rf_wsrc`=1, `imm`=0x5A. Next FETCH address is 0x02.
- HLT: memory[0]=0xE0. Required: `halted`=1 from cycle 3, `busy`=0, no `rf_we`. State remains HALT for 20 cycles despite `run`=1.
- Run drop: deassert `run` during EXEC of an ALU op. Required: WB still writes, then IDLE with `mem_addr`=0x01. Reasserting `run` fetches from 0x01.
- Wrap: RESET_PC=0xFF, memory[0xFF]=0xC0 (LDI r0), memory[0x00]=0x33. Required: r0 is written with 0x33, then the next FETCH address is 0x01.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU control path.
// Covers instruction field layout, opcode encoding and the sequencer state set.
package cpu_pkg;

    localparam int unsigned INSN_W  = 8;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned OPC_LSB = 5;
    localparam int unsigned RD_LSB  = 3;
    localparam int unsigned RS_LSB  = 1;

    // Opcodes 0-5 double as the result-mux select of the ALU datapath
    typedef enum logic [OPC_W-1:0] {
        OP_ALU0 = 3'd0,
        OP_ALU1 = 3'd1,
        OP_ALU2 = 3'd2,
        OP_ALU3 = 3'd3,
        OP_ALU4 = 3'd4,
        OP_ALU5 = 3'd5,
        OP_LDI  = 3'd6,
        OP_HLT  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LDI = 2'd1,
        CLS_HLT = 2'd2
    } op_class_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXEC      = 3'd3,
        ST_WB        = 3'd4,
        ST_IMM_FETCH = 3'd5,
        ST_IMM_LATCH = 3'd6,
        ST_HALT      = 3'd7
    } state_e;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decoder: splits an instruction byte into
// opcode class, ALU select and register fields.
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [INSN_W-1:0] insn_i,
    output op_class_e         op_class_o,
    output logic [OPC_W-1:0]  alu_sel_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [REG_W-1:0]  rs_o
);

    logic [OPC_W-1:0] opcode;
    logic             unused_bit0;

    assign opcode      = insn_i[OPC_LSB +: OPC_W];
    assign rd_o        = insn_i[RD_LSB +: REG_W];
    assign rs_o        = insn_i[RS_LSB +: REG_W];
    assign unused_bit0 = insn_i[0];

    // Non-ALU opcodes force the mux select back to 0
    always_comb begin
        op_class_o = CLS_ALU;
        alu_sel_o  = opcode;
        case (opcode)
            OP_LDI: begin
                op_class_o = CLS_LDI;
                alu_sel_o  = '0;
            end
            OP_HLT: begin
                op_class_o = CLS_HLT;
                alu_sel_o  = '0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit CPU.
// Outputs are Moore-decoded from the state, PC, IR and immediate registers.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [PC_W-1:0]   mem_addr,
    output logic              mem_rd,
    input  logic [INSN_W-1:0] mem_rdata,
    output logic [OPC_W-1:0]  alu_sel,
    output logic [REG_W-1:0]  rf_raddr_a,
    output logic [REG_W-1:0]  rf_raddr_b,
    output logic [REG_W-1:0]  rf_waddr,
    output logic              rf_we,
    output logic              rf_wsrc,
    output logic [INSN_W-1:0] imm,
    output logic              busy,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic [INSN_W-1:0] imm_q, imm_d;
    logic [INSN_W-1:0] dec_insn;
    op_class_e         dec_class;
    logic [OPC_W-1:0]  dec_alu_sel;
    logic [REG_W-1:0]  dec_rd, dec_rs;

    assign pc_inc = pc_q + PC_W'(1);
    assign imm    = imm_q;

    // DECODE branches on the byte arriving from memory; every later state uses IR
    assign dec_insn = (state_q == ST_DECODE) ? mem_rdata : ir_q;

    cpu_ctrl_decode u_decode (
        .insn_i     (dec_insn),
        .op_class_o (dec_class),
        .alu_sel_o  (dec_alu_sel),
        .rd_o       (dec_rd),
        .rs_o       (dec_rs)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        mem_addr   = pc_q;
        mem_rd     = 1'b0;
        alu_sel    = '0;
        rf_raddr_a = '0;
        rf_raddr_b = '0;
        rf_waddr   = '0;
        rf_we      = 1'b0;
        rf_wsrc    = 1'b0;
        busy       = (state_q != ST_IDLE) && (state_q != ST_HALT);
        halted     = (state_q == ST_HALT);

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_rd  = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = mem_rdata;
                case (dec_class)
                    CLS_ALU: state_d = ST_EXEC;
                    CLS_LDI: state_d = ST_IMM_FETCH;
                    default: state_d = ST_HALT;
                endcase
            end
            ST_EXEC: begin
                alu_sel    = dec_alu_sel;
                rf_raddr_a = dec_rd;
                rf_raddr_b = dec_rs;
                state_d    = ST_WB;
            end
            ST_IMM_FETCH: begin
                pc_d     = pc_inc;
                mem_rd   = 1'b1;
                mem_addr = pc_inc;
                state_d  = ST_IMM_LATCH;
            end
            ST_IMM_LATCH: begin
                imm_d   = mem_rdata;
                state_d = ST_WB;
            end
            ST_WB: begin
                alu_sel    = dec_alu_sel;
                rf_raddr_a = dec_rd;
                rf_raddr_b = dec_rs;
                rf_we      = 1'b1;
                rf_waddr   = dec_rd;
                rf_wsrc    = (dec_class == CLS_LDI);
                pc_d       = pc_inc;
                state_d    = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: ;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: reset, ALU, LDI, HLT, run drop and
// PC wrap, each against hand-computed expected outputs per cycle.
module tb_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       run_w;

    logic [7:0] mem   [256];
    logic [7:0] mem_w [256];

    logic [7:0] mem_addr, mem_rdata;
    logic       mem_rd, rf_we, rf_wsrc, busy, halted;
    logic [2:0] alu_sel;
    logic [1:0] rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [7:0] imm;

    logic [7:0] mem_addr_w, mem_rdata_w;
    logic       mem_rd_w, rf_we_w, rf_wsrc_w, busy_w, halted_w;
    logic [2:0] alu_sel_w;
    logic [1:0] rf_raddr_a_w, rf_raddr_b_w, rf_waddr_w;
    logic [7:0] imm_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Synchronous program memories: data one cycle after the read strobe
    always @(posedge clk) if (mem_rd)   mem_rdata   <= mem[mem_addr];
    always @(posedge clk) if (mem_rd_w) mem_rdata_w <= mem_w[mem_addr_w];

    cpu_control_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .alu_sel(alu_sel), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wsrc(rf_wsrc), .imm(imm),
        .busy(busy), .halted(halted)
    );

    cpu_control_fsm #(.PC_W(8), .RESET_PC(8'hFF)) dut_w (
        .clk(clk), .rst(rst), .run(run_w),
        .mem_addr(mem_addr_w), .mem_rd(mem_rd_w), .mem_rdata(mem_rdata_w),
        .alu_sel(alu_sel_w), .rf_raddr_a(rf_raddr_a_w), .rf_raddr_b(rf_raddr_b_w),
        .rf_waddr(rf_waddr_w), .rf_we(rf_we_w), .rf_wsrc(rf_wsrc_w), .imm(imm_w),
        .busy(busy_w), .halted(halted_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        int we_seen;
        int left_halt;

        rst   = 1'b1;
        run   = 1'b1;
        run_w = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'hE0;
            mem_w[i] = 8'hE0;
        end

        // Reset held with run=1
        mem[0] = 8'h2A;
        step(3);
        check("rst_busy",    32'(busy),     32'h0);
        check("rst_mem_rd",  32'(mem_rd),   32'h0);
        check("rst_mem_addr",32'(mem_addr), 32'h00);
        check("rst_rf_we",   32'(rf_we),    32'h0);
        check("rst_rf_wsrc", 32'(rf_wsrc),  32'h0);
        check("rst_alu_sel", 32'(alu_sel),  32'h0);
        check("rst_rf_waddr",32'(rf_waddr), 32'h0);
        check("rst_imm",     32'(imm),      32'h0);
        check("rst_halted",  32'(halted),   32'h0);
        check("rst_addr_w",  32'(mem_addr_w), 32'hFF);
        rst = 1'b0;

        // ALU op 0x2A: opcode 1, rd 1, rs 1
        step();
        check("alu_c1_mem_rd", 32'(mem_rd),   32'h1);
        check("alu_c1_addr",   32'(mem_addr), 32'h00);
        check("alu_c1_busy",   32'(busy),     32'h1);
        step();
        check("alu_c2_mem_rd", 32'(mem_rd),   32'h0);
        step();
        check("alu_c3_sel",    32'(alu_sel),    32'h1);
        check("alu_c3_ra",     32'(rf_raddr_a), 32'h1);
        check("alu_c3_rb",     32'(rf_raddr_b), 32'h1);
        check("alu_c3_we",     32'(rf_we),      32'h0);
        step();
        check("alu_c4_we",     32'(rf_we),    32'h1);
        check("alu_c4_waddr",  32'(rf_waddr), 32'h1);
        check("alu_c4_wsrc",   32'(rf_wsrc),  32'h0);
        check("alu_c4_sel",    32'(alu_sel),  32'h1);
        step();
        check("alu_next_addr", 32'(mem_addr), 32'h01);
        check("alu_next_rd",   32'(mem_rd),   32'h1);
        check("alu_next_we",   32'(rf_we),    32'h0);

        // LDI r2, 0x5A
        mem[0] = 8'hD0;
        mem[1] = 8'h5A;
        mem[2] = 8'hE0;
        do_reset();
        step(2);
        check("ldi_c2_busy",  32'(busy), 32'h1);
        step();
        check("ldi_c3_rd",    32'(mem_rd),   32'h1);
        check("ldi_c3_addr",  32'(mem_addr), 32'h01);
        step();
        check("ldi_c4_rd",    32'(mem_rd),   32'h0);
        check("ldi_c4_we",    32'(rf_we),    32'h0);
        step();
        check("ldi_c5_we",    32'(rf_we),    32'h1);
        check("ldi_c5_waddr", 32'(rf_waddr), 32'h2);
        check("ldi_c5_wsrc",  32'(rf_wsrc),  32'h1);
        check("ldi_c5_imm",   32'(imm),      32'h5A);
        step();
        check("ldi_next_addr", 32'(mem_addr), 32'h02);
        check("ldi_next_rd",   32'(mem_rd),   32'h1);

        // HLT is sticky while run stays high
        mem[0] = 8'hE0;
        do_reset();
        step(2);
        check("hlt_c2_halted", 32'(halted), 32'h0);
        step();
        check("hlt_c3_halted", 32'(halted), 32'h1);
        check("hlt_c3_busy",   32'(busy),   32'h0);
        check("hlt_c3_we",     32'(rf_we),  32'h0);
        we_seen   = 0;
        left_halt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rf_we)   we_seen++;
            if (!halted) left_halt++;
        end
        check("hlt_no_we",  32'(we_seen),   32'h0);
        check("hlt_sticky", 32'(left_halt), 32'h0);

        // run dropped during EXEC, then async reset during WB
        mem[0] = 8'h2A;
        mem[1] = 8'h4C;
        mem[2] = 8'hE0;
        do_reset();
        step(3);
        run = 1'b0;
        step();
        check("drop_wb_we",    32'(rf_we),    32'h1);
        check("drop_wb_waddr", 32'(rf_waddr), 32'h1);
        step();
        check("drop_idle_busy", 32'(busy),     32'h0);
        check("drop_idle_addr", 32'(mem_addr), 32'h01);
        check("drop_idle_rd",   32'(mem_rd),   32'h0);
        step();
        check("drop_park_busy", 32'(busy), 32'h0);
        run = 1'b1;
        step();
        check("resume_rd",   32'(mem_rd),   32'h1);
        check("resume_addr", 32'(mem_addr), 32'h01);
        step(2);
        check("resume_sel",  32'(alu_sel),    32'h2);
        check("resume_rb",   32'(rf_raddr_b), 32'h2);
        step();
        check("resume_we",   32'(rf_we), 32'h1);
        rst = 1'b1;
        #1;
        check("wb_rst_we",   32'(rf_we),    32'h0);
        check("wb_rst_busy", 32'(busy),     32'h0);
        check("wb_rst_addr", 32'(mem_addr), 32'h00);

        // PC wrap: LDI r0 at 0xFF takes its immediate from 0x00
        run   = 1'b0;
        run_w = 1'b1;
        mem_w[8'hFF] = 8'hC0;
        mem_w[8'h00] = 8'h33;
        mem_w[8'h01] = 8'hE0;
        do_reset();
        step();
        check("wrap_c1_addr", 32'(mem_addr_w), 32'hFF);
        check("wrap_c1_rd",   32'(mem_rd_w),   32'h1);
        step(2);
        check("wrap_c3_addr", 32'(mem_addr_w), 32'h00);
        check("wrap_c3_rd",   32'(mem_rd_w),   32'h1);
        step(2);
        check("wrap_c5_we",    32'(rf_we_w),    32'h1);
        check("wrap_c5_waddr", 32'(rf_waddr_w), 32'h0);
        check("wrap_c5_wsrc",  32'(rf_wsrc_w),  32'h1);
        check("wrap_c5_imm",   32'(imm_w),      32'h33);
        step();
        check("wrap_next_addr", 32'(mem_addr_w), 32'h01);
        check("wrap_next_rd",   32'(mem_rd_w),   32'h1);
        check("wrap_main_idle", 32'(busy),       32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
